// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle. It stalls the front of the pipeline until the result is ready.
module muldiv_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        StartE,
   input  logic [2:0]  MulDivOpE,
   input  logic [31:0] SrcA_E,
   input  logic [31:0] SrcB_E,
   input  logic        FlushE,
   output logic        StallMD,
   output logic        BusyMD,
   output logic        DoneMD,
   output logic [31:0] MulDivResultE
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] operand_q, operand_d;
   logic [2:0]  op_q, op_d;
   logic        negQuot_q, negQuot_d;
   logic        negRem_q, negRem_d;
   logic [31:0] result_q, result_d;

   logic        isDiv, signA, signB, negA, negB;
   logic [31:0] magA, magB;
   logic        divByZero, divOverflow, isSpecial;
   logic [31:0] specialResult;
   logic        launch;

   logic [32:0] mulSum;
   logic [32:0] divShift, divDiff;
   logic [63:0] stepAcc;
   logic [63:0] finalProd;
   logic [31:0] quotient, remainder;
   logic [31:0] finalResult;

   // Operand decode for the instruction sitting in execute.
   always_comb begin
      isDiv  = MulDivOpE[2];
      signA  = (MulDivOpE == OP_MULH) || (MulDivOpE == OP_MULHSU) ||
               (MulDivOpE == OP_DIV)  || (MulDivOpE == OP_REM);
      signB  = (MulDivOpE == OP_MULH) || (MulDivOpE == OP_DIV) || (MulDivOpE == OP_REM);
      negA   = signA && SrcA_E[31];
      negB   = signB && SrcB_E[31];
      magA   = negA ? (32'd0 - SrcA_E) : SrcA_E;
      magB   = negB ? (32'd0 - SrcB_E) : SrcB_E;

      divByZero   = isDiv && (SrcB_E == 32'd0);
      divOverflow = isDiv && !MulDivOpE[0] &&
                    (SrcA_E == 32'h8000_0000) && (SrcB_E == 32'hFFFF_FFFF);
      isSpecial   = divByZero || divOverflow;

      // MulDivOpE[1] distinguishes REM/REMU from DIV/DIVU.
      if (divByZero) begin
         specialResult = MulDivOpE[1] ? SrcA_E : 32'hFFFF_FFFF;
      end else begin
         specialResult = MulDivOpE[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // One iteration of the datapath. Multiply keeps {partial product, remaining multiplier}
   // in the accumulator; divide keeps {partial remainder, remaining dividend / quotient}.
   always_comb begin
      mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand_q} : 33'd0);
      divShift = {acc_q[63:32], acc_q[31]};
      divDiff  = divShift - {1'b0, operand_q};

      if (!op_q[2]) begin
         stepAcc = {mulSum, acc_q[31:1]};
      end else if (!divDiff[32]) begin
         stepAcc = {divDiff[31:0], acc_q[30:0], 1'b1};
      end else begin
         stepAcc = {divShift[31:0], acc_q[30:0], 1'b0};
      end

      finalProd = negQuot_q ? (64'd0 - stepAcc) : stepAcc;
      quotient  = negQuot_q ? (32'd0 - stepAcc[31:0]) : stepAcc[31:0];
      remainder = negRem_q ? (32'd0 - stepAcc[63:32]) : stepAcc[63:32];

      if (!op_q[2]) begin
         finalResult = (op_q == OP_MUL) ? finalProd[31:0] : finalProd[63:32];
      end else begin
         finalResult = op_q[1] ? remainder : quotient;
      end
   end

   assign launch = (state_q == IDLE) && StartE && !FlushE;

   // Next-state logic; the result register is only written on entry to DONE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      op_d      = op_q;
      negQuot_d = negQuot_q;
      negRem_d  = negRem_q;
      result_d  = result_q;

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               op_d      = MulDivOpE;
               cnt_d     = 6'd0;
               negQuot_d = negA ^ negB;
               negRem_d  = negA;
               if (isSpecial) begin
                  result_d = specialResult;
                  state_d  = DONE;
               end else begin
                  acc_d     = isDiv ? {32'd0, magA} : {32'd0, magB};
                  operand_d = isDiv ? magB : magA;
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            if (FlushE) begin
               state_d = IDLE;
            end else begin
               acc_d = stepAcc;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  result_d = finalResult;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         acc_q     <= 64'd0;
         operand_q <= 32'd0;
         op_q      <= 3'd0;
         negQuot_q <= 1'b0;
         negRem_q  <= 1'b0;
         result_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         op_q      <= op_d;
         negQuot_q <= negQuot_d;
         negRem_q  <= negRem_d;
         result_q  <= result_d;
      end
   end

   // Outputs are masked by rst because the state register only clears on the edge.
   always_comb begin
      StallMD = !rst && (launch || ((state_q == CALC) && !FlushE));
      BusyMD  = !rst && (state_q != IDLE);
      DoneMD  = !rst && (state_q == DONE);
   end

   assign MulDivResultE = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

   logic        clk;
   logic        rst;
   logic        StartE;
   logic [2:0]  MulDivOpE;
   logic [31:0] SrcA_E;
   logic [31:0] SrcB_E;
   logic        FlushE;
   logic        StallMD;
   logic        BusyMD;
   logic        DoneMD;
   logic [31:0] MulDivResultE;

   int checks;
   int failures;

   muldiv_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .StartE        (StartE),
      .MulDivOpE     (MulDivOpE),
      .SrcA_E        (SrcA_E),
      .SrcB_E        (SrcB_E),
      .FlushE        (FlushE),
      .StallMD       (StallMD),
      .BusyMD        (BusyMD),
      .DoneMD        (DoneMD),
      .MulDivResultE (MulDivResultE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit isSpecialRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return op[2] && ((b == 32'd0) ||
                       (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   // Reference arithmetic using 64-bit integers and the language's own / and %.
   function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = 64'd0;
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issues one instruction and waits for DoneMD. When chained, the operands are presented
   // during the previous DONE cycle and the start cycle is the following one.
   task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chained, input bit keepStart,
                        output int lat, output int stallCnt, output logic [31:0] res,
                        output bit busyAtStart);
      bit doneSeen;
      if (!chained) @(negedge clk);
      StartE    = 1'b1;
      MulDivOpE = op;
      SrcA_E    = a;
      SrcB_E    = b;
      if (chained) @(negedge clk);
      #1;
      busyAtStart = BusyMD;
      lat         = 1;
      stallCnt    = StallMD ? 1 : 0;
      doneSeen    = 1'b0;
      while (!doneSeen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (StallMD) stallCnt++;
         if (DoneMD) doneSeen = 1'b1;
      end
      res = MulDivResultE;
      if (!keepStart) StartE = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      StartE    = 1'b1;
      FlushE    = 1'b0;
      MulDivOpE = 3'd0;
      SrcA_E    = 32'd7;
      SrcB_E    = 32'd6;
      repeat (2) @(negedge clk);
      checks++;
      if (StallMD !== 1'b0) begin failures++; $display("[TB] FAIL reset StallMD: got %b expected 0", StallMD); end
      checks++;
      if (BusyMD !== 1'b0) begin failures++; $display("[TB] FAIL reset BusyMD: got %b expected 0", BusyMD); end
      checks++;
      if (DoneMD !== 1'b0) begin failures++; $display("[TB] FAIL reset DoneMD: got %b expected 0", DoneMD); end
      checks++;
      if (MulDivResultE !== 32'd0) begin failures++; $display("[TB] FAIL reset result: got %h expected 0", MulDivResultE); end
      StartE = 1'b0;
      rst    = 1'b0;
   endtask

   task automatic test_directed();
      logic [2:0]  opTab  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
      logic [31:0] aTab   [11] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                   32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
      logic [31:0] bTab   [11] = '{32'd6, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                                   32'd0, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] expTab [11] = '{32'h2A, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                   32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
      int          latTab [11] = '{34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2};
      int          lat, stallCnt;
      logic [31:0] res;
      bit          busy0;
      for (int i = 0; i < 11; i++) begin
         runOp(opTab[i], aTab[i], bTab[i], 1'b0, 1'b0, lat, stallCnt, res, busy0);
         checks++;
         if (res !== expTab[i]) begin failures++; $display("[TB] FAIL directed[%0d] result: got %h expected %h", i, res, expTab[i]); end
         checks++;
         if (lat !== latTab[i]) begin failures++; $display("[TB] FAIL directed[%0d] latency: got %0d expected %0d", i, lat, latTab[i]); end
         checks++;
         if (stallCnt !== latTab[i] - 1) begin failures++; $display("[TB] FAIL directed[%0d] stall cycles: got %0d expected %0d", i, stallCnt, latTab[i] - 1); end
      end
      @(negedge clk);
      checks++;
      if (DoneMD !== 1'b0) begin failures++; $display("[TB] FAIL done pulse width: got %b expected 0", DoneMD); end
      checks++;
      if (MulDivResultE !== 32'h8000_0000) begin failures++; $display("[TB] FAIL result hold: got %h expected 80000000", MulDivResultE); end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, res, expRes;
      int          lat, stallCnt, expLat;
      bit          busy0;
      for (int i = 0; i < 24; i++) begin
         op     = 3'($urandom_range(0, 7));
         a      = pickOperand();
         b      = pickOperand();
         expRes = refModel(op, a, b);
         expLat = isSpecialRef(op, a, b) ? 2 : 34;
         runOp(op, a, b, 1'b0, 1'b0, lat, stallCnt, res, busy0);
         checks++;
         if (res !== expRes) begin failures++; $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, expRes); end
         checks++;
         if (lat !== expLat) begin failures++; $display("[TB] FAIL random[%0d] latency: got %0d expected %0d", i, lat, expLat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] a, b, res, expRes;
      int          lat, stallCnt, expLat;
      bit          busy0;
      for (int i = 0; i < 4; i++) begin
         op     = 3'($urandom_range(0, 7));
         a      = pickOperand();
         b      = pickOperand();
         expRes = refModel(op, a, b);
         expLat = isSpecialRef(op, a, b) ? 2 : 34;
         runOp(op, a, b, (i != 0), (i != 3), lat, stallCnt, res, busy0);
         checks++;
         if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL b2b[%0d] busy at start: got %b expected 0", i, busy0); end
         checks++;
         if (res !== expRes) begin failures++; $display("[TB] FAIL b2b[%0d] result: got %h expected %h", i, res, expRes); end
         checks++;
         if (lat !== expLat) begin failures++; $display("[TB] FAIL b2b[%0d] latency: got %0d expected %0d", i, lat, expLat); end
      end
   endtask

   task automatic test_flush_calc();
      logic [31:0] res;
      int          lat, stallCnt;
      bit          busy0, doneSeen;
      runOp(3'd5, 32'd100, 32'd7, 1'b0, 1'b0, lat, stallCnt, res, busy0);
      @(negedge clk);
      StartE    = 1'b1;
      MulDivOpE = 3'd4;
      SrcA_E    = 32'd1000;
      SrcB_E    = 32'd3;
      repeat (10) @(negedge clk);
      FlushE = 1'b1;
      StartE = 1'b0;
      #1;
      checks++;
      if (StallMD !== 1'b0) begin failures++; $display("[TB] FAIL flush calc StallMD: got %b expected 0", StallMD); end
      @(negedge clk);
      FlushE = 1'b0;
      checks++;
      if (BusyMD !== 1'b0) begin failures++; $display("[TB] FAIL flush calc BusyMD: got %b expected 0", BusyMD); end
      doneSeen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (DoneMD) doneSeen = 1'b1;
      end
      checks++;
      if (doneSeen !== 1'b0) begin failures++; $display("[TB] FAIL flush calc DoneMD: got %b expected 0", doneSeen); end
      checks++;
      if (MulDivResultE !== 32'd14) begin failures++; $display("[TB] FAIL flush calc result: got %h expected %h", MulDivResultE, 32'd14); end
   endtask

   task automatic test_flush_done();
      logic [31:0] a, b, expRes;
      int          cyc;
      a      = $urandom;
      b      = $urandom;
      expRes = refModel(3'd3, a, b);
      @(negedge clk);
      StartE    = 1'b1;
      MulDivOpE = 3'd3;
      SrcA_E    = a;
      SrcB_E    = b;
      cyc       = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!DoneMD && cyc < 100);
      FlushE = 1'b1;
      StartE = 1'b0;
      #1;
      checks++;
      if (DoneMD !== 1'b1) begin failures++; $display("[TB] FAIL flush done DoneMD: got %b expected 1", DoneMD); end
      checks++;
      if (MulDivResultE !== expRes) begin failures++; $display("[TB] FAIL flush done result: got %h expected %h", MulDivResultE, expRes); end
      @(negedge clk);
      FlushE = 1'b0;
      checks++;
      if (BusyMD !== 1'b0) begin failures++; $display("[TB] FAIL flush done BusyMD: got %b expected 0", BusyMD); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          lat, stallCnt;
      bit          busy0;
      @(negedge clk);
      StartE    = 1'b1;
      MulDivOpE = 3'd0;
      SrcA_E    = 32'd12345;
      SrcB_E    = 32'd678;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({StallMD, BusyMD, DoneMD} !== 3'b000) begin failures++; $display("[TB] FAIL reset mid outputs: got %b expected 000", {StallMD, BusyMD, DoneMD}); end
      @(negedge clk);
      checks++;
      if (MulDivResultE !== 32'd0) begin failures++; $display("[TB] FAIL reset mid result: got %h expected 0", MulDivResultE); end
      rst    = 1'b0;
      StartE = 1'b0;
      #1;
      checks++;
      if (BusyMD !== 1'b0) begin failures++; $display("[TB] FAIL reset mid BusyMD: got %b expected 0", BusyMD); end
      runOp(3'd0, 32'd7, 32'd6, 1'b0, 1'b0, lat, stallCnt, res, busy0);
      checks++;
      if (res !== 32'h2A) begin failures++; $display("[TB] FAIL post reset result: got %h expected %h", res, 32'h2A); end
      checks++;
      if (lat !== 34) begin failures++; $display("[TB] FAIL post reset latency: got %0d expected 34", lat); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_flush_calc();
      test_flush_done();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
